// File: rtl/dfb1_pkg.sv
// Shared constants for the DFB1 SPI controller: register map, STAT bit
// positions, FSM encoding and reset values.
package dfb1_pkg;

    localparam logic [1:0] ADDR_ID   = 2'd0;
    localparam logic [1:0] ADDR_CFG  = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int STAT_BUSY_BIT = 7;
    localparam int STAT_OVR_BIT  = 6;
    localparam int STAT_SLOW_BIT = 1;
    localparam int STAT_CS_BIT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    localparam logic [7:0] RST_CFG   = 8'hFD;
    localparam logic [7:0] RST_RX    = 8'hFF;
    localparam logic [7:0] RST_RDATA = 8'hFF;
    localparam logic       RST_SLOW  = 1'b1;
    localparam logic       RST_CS_N  = 1'b1;

    // Assemble the STAT register image; unused bits read as zero.
    function automatic logic [7:0] stat_pack(input logic busy_v, input logic ovr_v,
                                             input logic slow_v, input logic cs_n_v);
        logic [7:0] v;
        v = 8'h00;
        v[STAT_BUSY_BIT] = busy_v;
        v[STAT_OVR_BIT]  = ovr_v;
        v[STAT_SLOW_BIT] = slow_v;
        v[STAT_CS_BIT]   = cs_n_v;
        return v;
    endfunction

endpackage

// File: rtl/dfb1_spi_tick.sv
// Half-period divider: while enabled, pulses tick once every div_load+1
// cycles; while disabled it keeps reloading so the first tick after enable
// arrives a full half-period later.
module dfb1_spi_tick (
    input  logic       CLKOSC,
    input  logic       RESET,
    input  logic       enable,
    input  logic [7:0] div_load,
    output logic       tick
);

    logic [7:0] cnt_r;

    // Down-counter with reload on terminal count or when idle.
    always_ff @(posedge CLKOSC) begin
        if (RESET) begin
            cnt_r <= 8'd0;
        end else if (!enable || cnt_r == 8'd0) begin
            cnt_r <= div_load;
        end else begin
            cnt_r <= cnt_r - 8'd1;
        end
    end

    assign tick = enable && (cnt_r == 8'd0);

endmodule

// File: rtl/dfb1_spi_ctrl.sv
// DFB1 SPI master: 4-register host interface, mode-0 MSB-first byte shifter
// with fast/slow clock divider and software-controlled chip select.
module dfb1_spi_ctrl
    import dfb1_pkg::*;
#(
    parameter int         DIV_FAST = 1,
    parameter int         DIV_SLOW = 50,
    parameter logic [7:0] ID_VALUE = 8'h01
) (
    input  logic       CLKOSC,
    input  logic       RESET,
    input  logic       reg_wr,
    input  logic       reg_rd,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic [7:0] cfg,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       busy
);

    localparam logic [7:0] DIV_FAST_M1 = 8'(DIV_FAST - 1);
    localparam logic [7:0] DIV_SLOW_M1 = 8'(DIV_SLOW - 1);

    spi_state_e state_r, state_nxt_s;
    logic [7:0] shreg_r, rx_r, cfg_r, rdata_r, div_load_s;
    logic [3:0] hp_r;
    logic       spi_clk_r, mosi_r, cs_n_r, slow_r, slow_lat_r, ovr_r, busy_r;
    logic       wr_data_s, start_s, tick_s, div_slow_s;

    assign wr_data_s = reg_wr && (reg_addr == ADDR_DATA);
    assign start_s   = wr_data_s && (state_r == ST_IDLE);
    // While idle the divider preloads from the live slow bit; once shifting
    // it uses the copy captured at transfer start, so STAT writes defer.
    assign div_slow_s = (state_r == ST_IDLE) ? slow_r : slow_lat_r;
    assign div_load_s = div_slow_s ? DIV_SLOW_M1 : DIV_FAST_M1;

    dfb1_spi_tick u_tick (
        .CLKOSC   (CLKOSC),
        .RESET    (RESET),
        .enable   (state_r == ST_SHIFT),
        .div_load (div_load_s),
        .tick     (tick_s)
    );

    // FSM state register.
    always_ff @(posedge CLKOSC) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: SHIFT ends on the tick closing half-period 16.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = start_s ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_nxt_s = (tick_s && hp_r == 4'd15) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Shift datapath: SPI clock, MOSI, shift register, rx capture, busy flag.
    always_ff @(posedge CLKOSC) begin
        if (RESET) begin
            shreg_r    <= 8'h00;
            rx_r       <= RST_RX;
            hp_r       <= 4'd0;
            spi_clk_r  <= 1'b0;
            mosi_r     <= 1'b1;
            slow_lat_r <= RST_SLOW;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    spi_clk_r <= 1'b0;
                    hp_r      <= 4'd0;
                    if (start_s) begin
                        shreg_r    <= reg_wdata;
                        mosi_r     <= reg_wdata[7];
                        slow_lat_r <= slow_r;
                    end else begin
                        mosi_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        hp_r <= hp_r + 4'd1;
                        if (!hp_r[0]) begin
                            // Odd half-period (1-based): rising edge, sample MISO.
                            spi_clk_r <= 1'b1;
                            shreg_r   <= {shreg_r[6:0], spi_miso};
                        end else begin
                            // Even half-period: falling edge, present next bit.
                            spi_clk_r <= 1'b0;
                            mosi_r    <= (hp_r == 4'd15) ? 1'b1 : shreg_r[7];
                        end
                    end
                end
                ST_DONE: begin
                    rx_r      <= shreg_r;
                    spi_clk_r <= 1'b0;
                    mosi_r    <= 1'b1;
                end
                default: begin
                    spi_clk_r <= 1'b0;
                    mosi_r    <= 1'b1;
                end
            endcase
        end
    end

    // Host-writable registers and the sticky overrun flag.
    always_ff @(posedge CLKOSC) begin
        if (RESET) begin
            cfg_r  <= RST_CFG;
            cs_n_r <= RST_CS_N;
            slow_r <= RST_SLOW;
            ovr_r  <= 1'b0;
        end else begin
            if (reg_wr && reg_addr == ADDR_CFG) begin
                cfg_r <= reg_wdata;
            end
            if (reg_wr && reg_addr == ADDR_STAT) begin
                cs_n_r <= reg_wdata[STAT_CS_BIT];
                slow_r <= reg_wdata[STAT_SLOW_BIT];
            end
            if (wr_data_s && state_r != ST_IDLE) begin
                ovr_r <= 1'b1;
            end else if (reg_rd && reg_addr == ADDR_STAT) begin
                ovr_r <= 1'b0;
            end
        end
    end

    // Registered read port; a DATA read during DONE forwards the new byte.
    always_ff @(posedge CLKOSC) begin
        if (RESET) begin
            rdata_r <= RST_RDATA;
        end else if (reg_rd) begin
            case (reg_addr)
                ADDR_ID:   rdata_r <= ID_VALUE;
                ADDR_CFG:  rdata_r <= cfg_r;
                ADDR_DATA: rdata_r <= (state_r == ST_DONE) ? shreg_r : rx_r;
                ADDR_STAT: rdata_r <= stat_pack(busy_r, ovr_r, slow_r, cs_n_r);
                default:   rdata_r <= 8'h00;
            endcase
        end
    end

    assign reg_rdata = rdata_r;
    assign cfg       = cfg_r;
    assign spi_clk   = spi_clk_r;
    assign spi_mosi  = mosi_r;
    assign spi_cs_n  = cs_n_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dfb1_spi_ctrl.sv
// Self-checking bench for dfb1_spi_ctrl: randomized transfers checked
// against a byte-level SPI slave model (bits seen on rising edges).
module tb_dfb1_spi_ctrl;

    logic       CLKOSC = 1'b0;
    logic       RESET  = 1'b1;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata, cfg;
    logic       spi_clk, spi_mosi, spi_miso, spi_cs_n, busy;

    int checks = 0;
    int errors = 0;

    // Slave model state.
    bit         loop_en = 1'b0;
    logic [7:0] miso_pat = 8'h00;
    logic [2:0] rise_idx = 3'd0;
    bit         mosi_q[$];
    time        rise_t = 0;
    time        hi_time = 0;

    dfb1_spi_ctrl #(.DIV_FAST(1), .DIV_SLOW(50), .ID_VALUE(8'h01)) dut (
        .CLKOSC(CLKOSC), .RESET(RESET), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .cfg(cfg), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .busy(busy)
    );

    always #5 CLKOSC = ~CLKOSC;

    assign spi_miso = loop_en ? spi_mosi : miso_pat[3'd7 - rise_idx];

    always @(posedge spi_clk) begin
        mosi_q.push_back(spi_mosi);
        rise_idx = rise_idx + 3'd1;
        rise_t = $time;
    end

    always @(negedge spi_clk) hi_time = $time - rise_t;

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLKOSC);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge CLKOSC);
        reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLKOSC);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge CLKOSC);
        reg_rd = 1'b0;
        d = reg_rdata;
    endtask

    task automatic arm_slave(input bit lp, input logic [7:0] pat);
        mosi_q.delete();
        rise_idx = 3'd0;
        loop_en = lp;
        miso_pat = pat;
    endtask

    // Count remaining busy cycles starting from the current negedge.
    task automatic wait_idle(inout int n);
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge CLKOSC);
        end
    endtask

    function automatic logic [7:0] q_byte();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], mosi_q[i]};
        return v;
    endfunction

    // Full transfer checked against the slave model.
    task automatic xfer(input string nm, input logic [7:0] tx, input bit lp,
                        input logic [7:0] pat, input int div);
        int n;
        logic [7:0] rd, exp_rx;
        arm_slave(lp, pat);
        reg_write(2'd2, tx);
        n = 0;
        wait_idle(n);
        checks++;
        if (n != 16 * div + 1) begin
            errors++; $display("FAIL %s busy_len: got %0d expected %0d", nm, n, 16 * div + 1);
        end
        checks++;
        if (mosi_q.size() != 8) begin
            errors++; $display("FAIL %s rise_count: got %0d expected 8", nm, mosi_q.size());
        end else if (q_byte() !== tx) begin
            errors++; $display("FAIL %s mosi_bits: got %h expected %h", nm, q_byte(), tx);
        end
        checks++;
        if (spi_clk !== 1'b0 || spi_mosi !== 1'b1) begin
            errors++; $display("FAIL %s idle_lines: clk=%b mosi=%b expected 0/1", nm, spi_clk, spi_mosi);
        end
        if (div > 1) begin
            checks++;
            if (hi_time != time'(div * 10)) begin
                errors++; $display("FAIL %s half_period: got %0t expected %0d", nm, hi_time, div * 10);
            end
        end
        exp_rx = lp ? tx : pat;
        reg_read(2'd2, rd);
        checks++;
        if (rd !== exp_rx) begin
            errors++; $display("FAIL %s rx_data: got %h expected %h", nm, rd, exp_rx);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'h01; exp_rd[1] = 8'hFD; exp_rd[2] = 8'hFF; exp_rd[3] = 8'h03;
        RESET = 1'b1;
        repeat (3) @(negedge CLKOSC);
        RESET = 1'b0;
        checks++;
        if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b1 || busy !== 1'b0
            || cfg !== 8'hFD || reg_rdata !== 8'hFF) begin
            errors++;
            $display("FAIL reset_outputs: cs_n=%b clk=%b mosi=%b busy=%b cfg=%h rdata=%h expected 1/0/1/0/fd/ff",
                     spi_cs_n, spi_clk, spi_mosi, busy, cfg, reg_rdata);
        end
        for (int a = 0; a < 4; a++) begin
            reg_read(2'(a), rd);
            checks++;
            if (rd !== exp_rd[a]) begin
                errors++; $display("FAIL reset_read%0d: got %h expected %h", a, rd, exp_rd[a]);
            end
        end
    endtask

    task automatic test_fast_basic();
        reg_write(2'd3, 8'h00);
        checks++;
        if (spi_cs_n !== 1'b0) begin
            errors++; $display("FAIL cs_follow: got %b expected 0", spi_cs_n);
        end
        xfer("fast_a5", 8'hA5, 1'b1, 8'h00, 1);
    endtask

    task automatic test_random();
        logic [7:0] c, rd;
        for (int i = 0; i < 8; i++) begin
            c = 8'($urandom);
            reg_write(2'd1, c);
            reg_read(2'd1, rd);
            checks++;
            if (rd !== c || cfg !== c) begin
                errors++; $display("FAIL rand_cfg: got %h/%h expected %h", rd, cfg, c);
            end
            xfer("rand_xfer", 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1);
        end
    endtask

    task automatic test_overrun();
        int n;
        logic [7:0] rd;
        arm_slave(1'b1, 8'h00);
        reg_write(2'd2, 8'h11);
        repeat (3) @(negedge CLKOSC);
        reg_write(2'd2, 8'h22);
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 8'hC0) begin
            errors++; $display("FAIL overrun_stat1: got %h expected c0", rd);
        end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 8'h80) begin
            errors++; $display("FAIL overrun_stat2: got %h expected 80", rd);
        end
        n = 0;
        wait_idle(n);
        checks++;
        if (mosi_q.size() != 8 || q_byte() !== 8'h11) begin
            errors++; $display("FAIL overrun_mosi: got %h (%0d bits) expected 11", q_byte(), mosi_q.size());
        end
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 8'h11) begin
            errors++; $display("FAIL overrun_rx: got %h expected 11", rd);
        end
    endtask

    task automatic test_deferred_slow();
        int n;
        logic [7:0] rd;
        arm_slave(1'b1, 8'h00);
        reg_write(2'd2, 8'h96);
        repeat (2) @(negedge CLKOSC);
        reg_write(2'd3, 8'h02);
        n = 4;
        wait_idle(n);
        checks++;
        if (n != 17) begin
            errors++; $display("FAIL deferred_busy: got %0d expected 17", n);
        end
        reg_read(2'd3, rd);
        checks++;
        if (rd !== 8'h02) begin
            errors++; $display("FAIL deferred_stat: got %h expected 02", rd);
        end
    endtask

    task automatic test_slow();
        xfer("slow_3c", 8'h3C, 1'b0, 8'h00, 50);
        reg_write(2'd3, 8'h00);
    endtask

    task automatic test_mid_reset();
        logic [7:0] rd;
        arm_slave(1'b1, 8'h00);
        reg_write(2'd2, 8'hC3);
        repeat (6) @(negedge CLKOSC);
        RESET = 1'b1;
        @(negedge CLKOSC);
        checks++;
        if (busy !== 1'b0 || spi_clk !== 1'b0 || spi_mosi !== 1'b1 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL midreset_lines: busy=%b clk=%b mosi=%b cs_n=%b expected 0/0/1/1",
                     busy, spi_clk, spi_mosi, spi_cs_n);
        end
        RESET = 1'b0;
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++; $display("FAIL midreset_rx: got %h expected ff", rd);
        end
        reg_write(2'd3, 8'h00);
    endtask

    task automatic test_done_read();
        int n;
        logic [7:0] rd;
        arm_slave(1'b1, 8'h00);
        reg_write(2'd2, 8'h5A);
        repeat (15) @(negedge CLKOSC);
        reg_read(2'd2, rd);
        checks++;
        if (rd !== 8'h5A) begin
            errors++; $display("FAIL done_read: got %h expected 5a", rd);
        end
        n = 0;
        wait_idle(n);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL done_timeout: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_fast_basic();
        test_random();
        test_overrun();
        test_deferred_slow();
        test_slow();
        test_mid_reset();
        test_done_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
